// File: rtl/vending_machine_param_pkg.sv
// vending_pkg: FSM states, default price/coin tables and packed-parameter slicing helpers
// shared by vending_machine_param and vm_credit_acc.
package vending_pkg;
    typedef enum logic [2:0] {IDLE, CHECK, COLLECT, VEND, REFUND} state_t;
    localparam int MAX_BITS = 256;
    localparam logic [15:0] DEF_PRICES = {4'd6, 4'd5, 4'd4, 4'd3};
    localparam logic [7:0] DEF_COINS = {4'd2, 4'd1};
    function automatic int unsigned slice_of(input logic [MAX_BITS-1:0] vec, input int unsigned idx, input int unsigned w);
        logic [MAX_BITS-1:0] s;
        s = vec >> (idx * w);
        return s[31:0] & ((32'd1 << w) - 32'd1);
    endfunction
    function automatic int unsigned price_of(input logic [MAX_BITS-1:0] prices, input int unsigned idx, input int unsigned w);
        return slice_of(prices, idx, w);
    endfunction
    function automatic int unsigned coin_value_of(input logic [MAX_BITS-1:0] coins, input int unsigned idx, input int unsigned w);
        return slice_of(coins, idx, w);
    endfunction
    function automatic logic onehot_check(input logic [15:0] v);
        return $onehot(v);
    endfunction
endpackage

// File: rtl/vending_machine_param_if.sv
// vending_machine_param_if: front-panel inputs and actuator outputs of the vending controller.
interface vending_machine_param_if #(
    parameter int NUM_ITEMS = 4,
    parameter int NUM_COINS = 2,
    parameter int CREDIT_W = 4
);
    localparam int IW = NUM_ITEMS > 1 ? $clog2(NUM_ITEMS) : 1;
    localparam int CW = NUM_COINS > 1 ? $clog2(NUM_COINS) : 1;
    logic [NUM_ITEMS-1:0] sel;
    logic [NUM_ITEMS-1:0] item_available;
    logic coin_valid;
    logic [CW-1:0] coin_idx;
    logic cnl;
    logic pdt;
    logic [IW-1:0] pdt_idx;
    logic [CREDIT_W-1:0] cng;
    logic [CREDIT_W-1:0] rtn;
    logic rtn_valid;
    logic coin_reject;
    logic sel_error;
    logic busy;
    logic [CREDIT_W-1:0] credit;
    modport master (
        output sel, item_available, coin_valid, coin_idx, cnl,
        input pdt, pdt_idx, cng, rtn, rtn_valid, coin_reject, sel_error, busy, credit
    );
    modport slave (
        input sel, item_available, coin_valid, coin_idx, cnl,
        output pdt, pdt_idx, cng, rtn, rtn_valid, coin_reject, sel_error, busy, credit
    );
endinterface

// File: rtl/vm_credit_acc.sv
// vm_credit_acc: credit register with overflow/invalid-coin rejection and idle timeout counter.
module vm_credit_acc
    import vending_pkg::*;
#(
    parameter int NUM_COINS = 2,
    parameter int CREDIT_W = 4,
    parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALUES = DEF_COINS,
    parameter int TIMEOUT_CYC = 64,
    localparam int CW = NUM_COINS > 1 ? $clog2(NUM_COINS) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic coin_valid,
    input  logic [CW-1:0] coin_idx,
    output logic [CREDIT_W-1:0] credit,
    output logic accept,
    output logic timeout
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [CREDIT_W-1:0] credit_q, credit_d, value;
    logic [CREDIT_W:0] sum;
    logic [TW-1:0] idle_q, idle_d;
    // The carry bit of sum flags a coin that would wrap the credit.
    always_comb begin
        value = CREDIT_W'(coin_value_of(MAX_BITS'(COIN_VALUES), 32'(coin_idx), CREDIT_W));
        sum = {1'b0, credit_q} + {1'b0, value};
        accept = en && coin_valid && 32'(coin_idx) < NUM_COINS && !sum[CREDIT_W];
        timeout = en && !coin_valid && idle_q == TW'(TIMEOUT_CYC - 1);
        credit_d = clr ? '0 : accept ? sum[CREDIT_W-1:0] : credit_q;
        idle_d = (!en || accept) ? '0 : coin_valid ? idle_q : idle_q + TW'(1);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_q <= '0;
            idle_q <= '0;
        end else begin
            credit_q <= credit_d;
            idle_q <= idle_d;
        end
    end
    assign credit = credit_q;
endmodule

// File: rtl/vending_machine_param.sv
// vending_machine_param: parametrised vending controller with exact change and idle refund.
// Optional per-item sales counters on port sales_cnt when VM_SALES_COUNT_EN is defined.
module vending_machine_param
    import vending_pkg::*;
#(
    parameter int NUM_ITEMS = 4,
    parameter int NUM_COINS = 2,
    parameter int CREDIT_W = 4,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] ITEM_PRICES = DEF_PRICES,
    parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALUES = DEF_COINS,
    parameter int TIMEOUT_CYC = 64
) (
    input logic clk,
    input logic rst,
    vending_machine_param_if.slave vm
`ifdef VM_SALES_COUNT_EN
    ,
    output logic [NUM_ITEMS*16-1:0] sales_cnt
`endif
);
    localparam int IW = NUM_ITEMS > 1 ? $clog2(NUM_ITEMS) : 1;
    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_chk
        if (price_of(MAX_BITS'(ITEM_PRICES), i, CREDIT_W) == 0) begin : g_zero
            $error("vending_machine_param: item %0d has a zero price", i);
        end
    end
    if (TIMEOUT_CYC < 2) begin : g_tmo
        $error("vending_machine_param: TIMEOUT_CYC must be at least 2");
    end
    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, sel_idx, pdt_idx_q, pdt_idx_d;
    logic [CREDIT_W-1:0] price, credit, cng_q, cng_d, rtn_q, rtn_d;
    logic pdt_q, pdt_d, rtn_valid_q, rtn_valid_d, coin_reject_q, coin_reject_d;
    logic sel_error_q, sel_error_d, busy_q, busy_d;
    logic accept, timeout, enough, en;
    assign price = CREDIT_W'(price_of(MAX_BITS'(ITEM_PRICES), 32'(idx_q), CREDIT_W));
    assign enough = credit >= price;
    assign en = state_q == COLLECT && !vm.cnl && !enough;
    vm_credit_acc #(
        .NUM_COINS(NUM_COINS),
        .CREDIT_W(CREDIT_W),
        .COIN_VALUES(COIN_VALUES),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_acc (
        .clk(clk),
        .rst(rst),
        .en(en),
        .clr(state_q == VEND || state_q == REFUND),
        .coin_valid(vm.coin_valid),
        .coin_idx(vm.coin_idx),
        .credit(credit),
        .accept(accept),
        .timeout(timeout)
    );
    // Any coin the accumulator did not take is bounced, whatever the state.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_ITEMS; i++) if (vm.sel[i]) sel_idx = IW'(i);
        state_d = state_q;
        idx_d = idx_q;
        pdt_d = 1'b0;
        pdt_idx_d = '0;
        cng_d = '0;
        rtn_d = '0;
        rtn_valid_d = 1'b0;
        sel_error_d = 1'b0;
        coin_reject_d = vm.coin_valid && !accept;
        case (state_q)
            IDLE: begin
                if (onehot_check(16'(vm.sel))) begin
                    idx_d = sel_idx;
                    state_d = CHECK;
                end else sel_error_d = |vm.sel;
            end
            CHECK: begin
                state_d = vm.item_available[idx_q] ? COLLECT : IDLE;
                sel_error_d = !vm.item_available[idx_q];
            end
            COLLECT: begin
                if (vm.cnl || timeout) begin
                    state_d = REFUND;
                    rtn_valid_d = 1'b1;
                    rtn_d = credit;
                end else if (enough) begin
                    state_d = VEND;
                    pdt_d = 1'b1;
                    pdt_idx_d = idx_q;
                    cng_d = credit - price;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q <= '0;
            pdt_q <= 1'b0;
            pdt_idx_q <= '0;
            cng_q <= '0;
            rtn_q <= '0;
            rtn_valid_q <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_error_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            pdt_q <= pdt_d;
            pdt_idx_q <= pdt_idx_d;
            cng_q <= cng_d;
            rtn_q <= rtn_d;
            rtn_valid_q <= rtn_valid_d;
            coin_reject_q <= coin_reject_d;
            sel_error_q <= sel_error_d;
            busy_q <= busy_d;
        end
    end
    assign vm.pdt = pdt_q;
    assign vm.pdt_idx = pdt_idx_q;
    assign vm.cng = cng_q;
    assign vm.rtn = rtn_q;
    assign vm.rtn_valid = rtn_valid_q;
    assign vm.coin_reject = coin_reject_q;
    assign vm.sel_error = sel_error_q;
    assign vm.busy = busy_q;
    assign vm.credit = credit;
`ifdef VM_SALES_COUNT_EN
    logic [15:0] sales_q [NUM_ITEMS];
    logic [15:0] sales_d [NUM_ITEMS];
    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++)
            sales_d[i] = sales_q[i] + 16'(pdt_q && pdt_idx_q == IW'(i) && sales_q[i] != 16'hFFFF);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ITEMS; i++) sales_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) sales_q[i] <= sales_d[i];
        end
    end
    for (genvar k = 0; k < NUM_ITEMS; k++) begin : g_sales
        assign sales_cnt[k*16 +: 16] = sales_q[k];
    end
`endif
endmodule

// File: tb/tb_vending_machine_param.sv
// tb_vending_machine_param: randomized and directed stimulus, reference model feeding a
// scoreboard of expected pulses and status, popped by an independent negedge monitor.
module tb_vending_machine_param;
    localparam int NI = 4;
    localparam int NC = 3;
    localparam int CWD = 4;
    localparam int TMO = 12;
    localparam logic [15:0] PRICES = {4'd13, 4'd5, 4'd4, 4'd3};
    localparam logic [11:0] COINS = {4'd5, 4'd2, 4'd1};
    int price_tab [NI] = '{3, 4, 5, 13};
    int coin_tab [NC] = '{1, 2, 5};
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    vending_machine_param_if #(.NUM_ITEMS(NI), .NUM_COINS(NC), .CREDIT_W(CWD)) vif ();
`ifdef VM_SALES_COUNT_EN
    logic [NI*16-1:0] sales_cnt;
`endif
    vending_machine_param #(
        .NUM_ITEMS(NI),
        .NUM_COINS(NC),
        .CREDIT_W(CWD),
        .ITEM_PRICES(PRICES),
        .COIN_VALUES(COINS),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vm(vif)
`ifdef VM_SALES_COUNT_EN
        ,
        .sales_cnt(sales_cnt)
`endif
    );
    typedef struct {int cyc; logic [13:0] v;} ev_t;
    typedef struct {int cyc; logic busy; logic [3:0] credit;} st_t;
    ev_t evq[$];
    st_t stq[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    always @(posedge clk) cyc <= cyc + 1;
    // Session model: 0 waiting for a choice, 1 checking stock, 2 paying, 3 closing.
    int ph = 0;
    int item = 0;
    int m_credit = 0;
    int idle = 0;
    int sold [NI] = '{0, 0, 0, 0};
    task automatic predict(input logic r);
        logic pdt, rv, cr, se, took;
        int pidx, cng, rtn, ci, val;
        pdt = 0; rv = 0; se = 0; took = 0; pidx = 0; cng = 0; rtn = 0;
        ci = int'(vif.coin_idx);
        val = ci < NC ? coin_tab[ci] : 0;
        if (!r) begin
            ph = 0; item = 0; m_credit = 0; idle = 0;
        end else if (ph == 0) begin
            if ($countones(vif.sel) == 1) begin
                for (int i = 0; i < NI; i++) if (vif.sel[i]) item = i;
                ph = 1;
            end else se = vif.sel != 0;
        end else if (ph == 1) begin
            if (vif.item_available[item]) begin ph = 2; idle = 0; end
            else begin se = 1; ph = 0; end
        end else if (ph == 2) begin
            if (vif.cnl) begin
                rv = 1; rtn = m_credit; ph = 3;
            end else if (m_credit >= price_tab[item]) begin
                pdt = 1; pidx = item; cng = m_credit - price_tab[item]; ph = 3; sold[item]++;
            end else if (vif.coin_valid) begin
                if (ci < NC && m_credit + val <= 15) begin m_credit += val; idle = 0; took = 1; end
            end else begin
                idle++;
                if (idle == TMO) begin rv = 1; rtn = m_credit; ph = 3; end
            end
        end else begin
            ph = 0; m_credit = 0;
        end
        cr = r && vif.coin_valid && !took;
        if ({pdt, rv, cr, se} != 0 || cng != 0 || rtn != 0)
            evq.push_back('{cyc + 1, {pdt, 2'(pidx), 4'(cng), rv, 4'(rtn), cr, se}});
        stq.push_back('{cyc + 1, ph != 0, 4'(m_credit)});
    endtask
    task automatic drive(input logic [3:0] s, input logic cv, input logic [1:0] ci, input logic cn);
        vif.sel = s; vif.coin_valid = cv; vif.coin_idx = ci; vif.cnl = cn;
        predict(rst);
        @(posedge clk);
        #1;
    endtask
    task automatic reset_mid();
        vif.sel = 0; vif.coin_valid = 0; vif.coin_idx = 0; vif.cnl = 0;
        predict(1'b0);
        @(negedge clk);
        #1 rst = 0;
        #1;
        checks++;
        if ({vif.pdt, vif.pdt_idx, vif.cng, vif.rtn, vif.rtn_valid, vif.coin_reject, vif.sel_error, vif.busy, vif.credit} !== '0) begin
            errors++;
            $display("FAIL async_reset got busy=%b credit=%0d rtn_valid=%b required all zero", vif.busy, vif.credit, vif.rtn_valid);
        end
        @(posedge clk);
        #1;
    endtask
    ev_t mev;
    st_t mst;
    logic [13:0] got;
    initial forever begin
        @(negedge clk);
        while (evq.size() > 0 && evq[0].cyc < cyc) begin
            mev = evq.pop_front();
            checks++; errors++;
            $display("FAIL missed_event cyc=%0d got none required=%h", mev.cyc, mev.v);
        end
        got = {vif.pdt, vif.pdt_idx, vif.cng, vif.rtn_valid, vif.rtn, vif.coin_reject, vif.sel_error};
        checks++;
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
            mev = evq.pop_front();
            if (got !== mev.v) begin
                errors++;
                $display("FAIL event cyc=%0d got=%h required=%h", cyc, got, mev.v);
            end
        end else if (got !== 14'd0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d got=%h required=0", cyc, got);
        end
        if (stq.size() > 0 && stq[0].cyc == cyc) begin
            mst = stq.pop_front();
            checks++;
            if ({vif.busy, vif.credit} !== {mst.busy, mst.credit}) begin
                errors++;
                $display("FAIL status cyc=%0d got busy=%b credit=%0d required busy=%b credit=%0d",
                         cyc, vif.busy, vif.credit, mst.busy, mst.credit);
            end
        end
    end
    initial begin
        logic [3:0] s;
        vif.item_available = '1;
        repeat (3) drive(0, 0, 0, 0);
        rst = 1;
        drive(0, 0, 0, 0);
        // item0 at 3: coins 2,2 -> change 1
        drive(4'b0001, 0, 0, 0); drive(0, 0, 0, 0);
        drive(0, 1, 1, 0); drive(0, 1, 1, 0);
        repeat (3) drive(0, 0, 0, 0);
        // item3: coins 2,1,2 then cancel with a simultaneous coin
        drive(4'b1000, 0, 0, 0); drive(0, 0, 0, 0);
        drive(0, 1, 1, 0); drive(0, 1, 0, 0); drive(0, 1, 1, 0);
        drive(0, 1, 2, 1);
        repeat (2) drive(0, 0, 0, 0);
        // unavailable item, coin while checking, coin in idle
        vif.item_available = 4'b1011;
        drive(4'b0100, 0, 0, 0); drive(0, 1, 0, 0);
        drive(0, 0, 0, 0); drive(0, 1, 1, 0);
        vif.item_available = '1;
        // timeout refund then a non-one-hot selection
        drive(4'b0010, 0, 0, 0); drive(0, 0, 0, 0); drive(0, 1, 0, 0);
        repeat (TMO + 2) drive(0, 0, 0, 0);
        drive(4'b0011, 0, 0, 0); drive(0, 0, 0, 0);
        // overflow and invalid coins, exact price, coin during vend
        drive(4'b1000, 0, 0, 0); drive(0, 0, 0, 0);
        drive(0, 1, 2, 0); drive(0, 1, 2, 0); drive(0, 1, 1, 0);
        drive(0, 1, 2, 0); drive(0, 1, 3, 0); drive(0, 1, 0, 0);
        drive(0, 1, 1, 0); drive(0, 1, 1, 0);
        repeat (2) drive(0, 0, 0, 0);
        // stock withdrawn after the item was reserved
        drive(4'b0100, 0, 0, 0); drive(0, 0, 0, 0);
        vif.item_available = 4'b1011;
        drive(0, 1, 1, 0); drive(0, 1, 2, 0);
        repeat (3) drive(0, 0, 0, 0);
        vif.item_available = '1;
        // asynchronous reset with credit 4 held
        drive(4'b1000, 0, 0, 0); drive(0, 0, 0, 0);
        drive(0, 1, 1, 0); drive(0, 1, 1, 0);
        reset_mid();
        drive(0, 0, 0, 0);
        rst = 1;
        drive(0, 0, 0, 0);
        repeat (500) begin
            if ($urandom_range(0, 39) == 0) repeat (TMO + 1) drive(0, 0, 0, 0);
            if ($urandom_range(0, 19) == 0) vif.item_available = 4'($urandom);
            s = $urandom_range(0, 9) == 0 ? 4'($urandom) : $urandom_range(0, 4) == 0 ? 4'b0001 << $urandom_range(0, 3) : 4'b0000;
            drive(s, $urandom_range(0, 2) == 0, 2'($urandom), $urandom_range(0, 29) == 0);
        end
        repeat (4) drive(0, 0, 0, 0);
        @(negedge clk);
        #1;
        while (evq.size() > 0) begin
            mev = evq.pop_front();
            checks++; errors++;
            $display("FAIL leftover_event cyc=%0d got none required=%h", mev.cyc, mev.v);
        end
`ifdef VM_SALES_COUNT_EN
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (sales_cnt[i*16 +: 16] !== 16'(sold[i])) begin
                errors++;
                $display("FAIL sales_cnt[%0d] got=%0d required=%0d", i, sales_cnt[i*16 +: 16], sold[i]);
            end
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
